// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: RAM-side port bundle of the IF/MEM arbiter.
// master = arbiter (drives address/enable/data/mask), slave = RAM (drives data and handshakes).
interface ram_arbiter_if #(
    parameter int AW = 32
);
    logic [AW-1:0] ram_raddr_o;
    logic          ram_ren_o;
    logic [AW-1:0] ram_waddr_o;
    logic [63:0]   ram_wdata_o;
    logic [63:0]   ram_wmask_o;
    logic          ram_wen_o;
    logic [63:0]   ram_rdata_i;
    logic          ram_rready_i;
    logic          ram_wready_i;
    logic          ram_bvalid_i;

    modport master (
        output ram_raddr_o, ram_ren_o, ram_waddr_o, ram_wdata_o, ram_wmask_o, ram_wen_o,
        input  ram_rdata_i, ram_rready_i, ram_wready_i, ram_bvalid_i
    );

    modport slave (
        input  ram_raddr_o, ram_ren_o, ram_waddr_o, ram_wdata_o, ram_wmask_o, ram_wen_o,
        output ram_rdata_i, ram_rready_i, ram_wready_i, ram_bvalid_i
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port data RAM between instruction fetch (32-bit reads)
// and the memory stage (64-bit loads/stores), one transaction at a time.
// Build option ARB_RR_EN: round-robin arbitration. Without it, MEM has priority and IF
// is forced through after STARVE_MAX consecutive MEM grants while it waits.
module ram_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [31:0]   if_rdata_o,
    input  logic          mem_req_i,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [63:0]   mem_wdata_i,
    input  logic [63:0]   mem_wmask_i,
    output logic          mem_gnt_o,
    output logic          mem_rvalid_o,
    output logic [63:0]   mem_rdata_o,
    output logic          mem_bvalid_o,
    output logic          busy_o,
    ram_arbiter_if.master ram
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_WR    = 2'd2,
        ST_WRESP = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          grant_if_s, grant_mem_s;
    logic          owner_q, owner_d;        // 1 = IF owns the transaction, 0 = MEM
    logic [AW-1:0] raddr_q, raddr_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   wmask_q, wmask_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [63:0]   mem_rdata_q, mem_rdata_d;
    logic          if_gnt_q, if_gnt_d;
    logic          mem_gnt_q, mem_gnt_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          mem_rvalid_q, mem_rvalid_d;
    logic          mem_bvalid_q, mem_bvalid_d;
    logic          ren_q, ren_d;
    logic          wen_q, wen_d;
    logic          busy_q, busy_d;

`ifdef ARB_RR_EN
    localparam logic PRIO_MEM = 1'b0;
    localparam logic PRIO_IF  = 1'b1;
    logic prio_q, prio_d;                   // who wins the next contested arbitration
`else
    localparam int            CW      = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);
    logic [CW-1:0] cnt_q, cnt_d;            // consecutive MEM grants while IF waited
`endif

    // Pick the winner among the current requests; only IDLE accepts new work.
    always_comb begin
        grant_if_s  = 1'b0;
        grant_mem_s = 1'b0;
        if (state_q == ST_IDLE) begin
            if (if_req_i && mem_req_i) begin
`ifdef ARB_RR_EN
                grant_if_s  = (prio_q == PRIO_IF);
                grant_mem_s = (prio_q == PRIO_MEM);
`else
                grant_if_s  = (cnt_q == CNT_MAX);
                grant_mem_s = (cnt_q != CNT_MAX);
`endif
            end else begin
                grant_if_s  = if_req_i;
                grant_mem_s = mem_req_i;
            end
        end else begin
            grant_if_s  = 1'b0;
            grant_mem_s = 1'b0;
        end
    end

    // Update the fairness state on every grant.
    always_comb begin
`ifdef ARB_RR_EN
        if (grant_if_s) begin
            prio_d = PRIO_MEM;
        end else if (grant_mem_s) begin
            prio_d = PRIO_IF;
        end else begin
            prio_d = prio_q;
        end
`else
        if (grant_if_s) begin
            cnt_d = {CW{1'b0}};
        end else if (grant_mem_s && if_req_i) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (grant_mem_s) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_if_s) begin
                    state_d = ST_RD;
                end else if (grant_mem_s) begin
                    state_d = mem_we_i ? ST_WR : ST_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD:    state_d = ram.ram_rready_i ? ST_IDLE : ST_RD;
            ST_WR:    state_d = ram.ram_wready_i ? ST_WRESP : ST_WR;
            ST_WRESP: state_d = ram.ram_bvalid_i ? ST_IDLE : ST_WRESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of all registered outputs and latched fields.
    always_comb begin
        owner_d      = owner_q;
        raddr_d      = raddr_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_gnt_d     = 1'b0;
        mem_gnt_d    = 1'b0;
        if_rvalid_d  = 1'b0;
        mem_rvalid_d = 1'b0;
        mem_bvalid_d = 1'b0;
        // Enables follow the state being entered, so they go high with the grant
        // and drop in the cycle after the RAM handshake completes.
        ren_d        = (state_d == ST_RD);
        wen_d        = (state_d == ST_WR);
        busy_d       = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (grant_if_s) begin
                    owner_d  = 1'b1;
                    if_gnt_d = 1'b1;
                    raddr_d  = if_addr_i;
                end else if (grant_mem_s) begin
                    owner_d   = 1'b0;
                    mem_gnt_d = 1'b1;
                    if (mem_we_i) begin
                        waddr_d = mem_addr_i;
                        wdata_d = mem_wdata_i;
                        wmask_d = mem_wmask_i;
                    end else begin
                        raddr_d = mem_addr_i;
                    end
                end else begin
                    owner_d = owner_q;
                end
            end
            ST_RD: begin
                if (ram.ram_rready_i && owner_q) begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = ram.ram_rdata_i[31:0];
                end else if (ram.ram_rready_i) begin
                    mem_rvalid_d = 1'b1;
                    mem_rdata_d  = ram.ram_rdata_i;
                end else begin
                    raddr_d = raddr_q;
                end
            end
            ST_WR: begin
                waddr_d = waddr_q;
            end
            ST_WRESP: begin
                if (ram.ram_bvalid_i) begin
                    mem_bvalid_d = 1'b1;
                end else begin
                    mem_bvalid_d = 1'b0;
                end
            end
            default: begin
                owner_d = owner_q;
            end
        endcase
    end

    // Output, datapath and arbitration registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= 1'b0;
            raddr_q      <= {AW{1'b0}};
            waddr_q      <= {AW{1'b0}};
            wdata_q      <= 64'd0;
            wmask_q      <= 64'd0;
            if_rdata_q   <= 32'd0;
            mem_rdata_q  <= 64'd0;
            if_gnt_q     <= 1'b0;
            mem_gnt_q    <= 1'b0;
            if_rvalid_q  <= 1'b0;
            mem_rvalid_q <= 1'b0;
            mem_bvalid_q <= 1'b0;
            ren_q        <= 1'b0;
            wen_q        <= 1'b0;
            busy_q       <= 1'b0;
`ifdef ARB_RR_EN
            prio_q       <= PRIO_MEM;
`else
            cnt_q        <= {CW{1'b0}};
`endif
        end else begin
            owner_q      <= owner_d;
            raddr_q      <= raddr_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_gnt_q     <= if_gnt_d;
            mem_gnt_q    <= mem_gnt_d;
            if_rvalid_q  <= if_rvalid_d;
            mem_rvalid_q <= mem_rvalid_d;
            mem_bvalid_q <= mem_bvalid_d;
            ren_q        <= ren_d;
            wen_q        <= wen_d;
            busy_q       <= busy_d;
`ifdef ARB_RR_EN
            prio_q       <= prio_d;
`else
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign if_gnt_o        = if_gnt_q;
    assign if_rvalid_o     = if_rvalid_q;
    assign if_rdata_o      = if_rdata_q;
    assign mem_gnt_o       = mem_gnt_q;
    assign mem_rvalid_o    = mem_rvalid_q;
    assign mem_rdata_o     = mem_rdata_q;
    assign mem_bvalid_o    = mem_bvalid_q;
    assign busy_o          = busy_q;
    assign ram.ram_raddr_o = raddr_q;
    assign ram.ram_ren_o   = ren_q;
    assign ram.ram_waddr_o = waddr_q;
    assign ram.ram_wdata_o = wdata_q;
    assign ram.ram_wmask_o = wmask_q;
    assign ram.ram_wen_o   = wen_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data RAM.
- Shares the RAM port between instruction fetch (IF, read-only, 32-bit instruction) and the memory stage (MEM, 64-bit load/store).
- Serialises one transaction at a time through a small FSM.
- Drives the RAM's address/enable/data/mask lines and consumes its rready/wready/bvalid handshake.

Parameters:
- STARVE_MAX, 4: max consecutive MEM grants while IF is waiting before IF is forced through (>=1).
- AW, 32: RAM address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req_i  in  1  IF read request; held with if_addr_i until if_gnt_o.
- if_addr_i  in  AW  IF byte address.
- if_gnt_o  out  1  one-cycle grant pulse to IF.
- if_rvalid_o  out  1  one-cycle pulse; if_rdata_o valid.
- if_rdata_o  out  32  instruction, ram_rdata_i[31:0] captured.
- mem_req_i  in  1  MEM request; held with address, data, mask and mem_we_i until mem_gnt_o.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_addr_i  in  AW  MEM byte address.
- mem_wdata_i  in  64  store data.
- mem_wmask_i  in  64  store bit mask.
- mem_gnt_o  out  1  one-cycle grant pulse to MEM.
- mem_rvalid_o  out  1  one-cycle pulse; mem_rdata_o valid.
- mem_rdata_o  out  64  load data.
- mem_bvalid_o  out  1  one-cycle store-complete pulse.
- ram_raddr_o  out  AW  RAM read address.
- ram_ren_o  out  1  RAM read enable.
- ram_waddr_o  out  AW  RAM write address.
- ram_wdata_o  out  64  RAM write data.
- ram_wmask_o  out  64  RAM write mask.
- ram_wen_o  out  1  RAM write enable.
- ram_rdata_i  in  64  RAM read data.
- ram_rready_i  in  1  RAM read data ready.
- ram_wready_i  in  1  RAM accepts write this cycle.
- ram_bvalid_i  in  1  RAM write response.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0, async):
  - State = IDLE; starvation counter = 0; RR pointer = MEM.
  - All outputs 0, including all data and address registers.
  - An in-flight transaction is dropped with no rvalid or bvalid pulse. A RAM write already issued is not undone.
- FSM states: IDLE, RD, WR, WRESP. All outputs are registered.
- IDLE:
  - Arbitrate; on a winner, latch its address, data, mask and owner.
  - Pulse the winner's gnt_o next cycle.
  - Go to RD (IF, or MEM with we=0) or WR (MEM with we=1).
  - No request: stay in IDLE.
- RD:
  - ram_ren_o=1, ram_raddr_o = latched address.
  - If ram_rready_i=1: capture ram_rdata_i, pulse the owner's rvalid next cycle, return to IDLE.
  - Otherwise hold, with ram_ren_o kept at 1.
- WR:
  - ram_wen_o=1, with ram_waddr_o/wdata_o/wmask_o latched.
  - If ram_wready_i=1: go to WRESP and drop ram_wen_o. The write is issued exactly once.
- WRESP:
  - Wait for ram_bvalid_i=1, then pulse mem_bvalid_o next cycle and return to IDLE.
- Latency with an always-ready RAM:
  - Read: req in cycle 0 -> gnt in cycle 1 (ram_ren_o=1) -> rvalid in cycle 2.
  - Write: gnt in cycle 1 -> ram_wen_o in cycle 1 -> bvalid_i in cycle 2 -> mem_bvalid_o in cycle 3.
- Back-to-back: a request still high when the FSM re-enters IDLE is a new request; there is no bubble beyond the IDLE cycle.
- Arbitration (default):
  - MEM has priority.
  - Counter increments on each MEM grant while if_req_i=1, saturating at STARVE_MAX.
  - When the counter equals STARVE_MAX and both request, IF wins.
  - Any IF grant clears the counter; a MEM grant with if_req_i=0 also clears it.
- Requests arriving while busy_o=1 are ignored until IDLE.
- Address and data are passed through unmodified; alignment is the RAM's job.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both request, the requester not granted last wins.
  - A single requester always wins.
  - Starvation counter held at 0.
- Undefined: MEM priority with the STARVE_MAX guard, as above.

Test Plan:
- Reset: rst=0 during RD with ram_rready_i=0 -> all outputs 0 immediately and busy_o=0. After release, no if_rvalid_o/mem_rvalid_o ever appears for the dropped read.
- IF read, addr 0x80000004, RAM always ready, ram_rdata_i=0xDEADBEEF00000013:
  - if_gnt_o and ram_ren_o in cycle 1 with ram_raddr_o=0x80000004.
  - if_rvalid_o in cycle 2 with if_rdata_o=0x00000013.
- MEM store, addr 0x80000010, data 0x1122334455667788, mask all-ones:
  - ram_wen_o high exactly one cycle (cycle 1) with those values.
  - ram_bvalid_i in cycle 2 -> mem_bvalid_o in cycle 3.
- Stalled read: ram_rready_i=0 for 5 cycles -> ram_ren_o and ram_raddr_o stable, no rvalid; rvalid exactly one cycle after rready rises.
- ARB_RR_EN undefined, STARVE_MAX=4, both requesting continuously -> grant sequence M,M,M,M,I,M,M,M,M,I.
- ARB_RR_EN defined, both requesting continuously -> grant sequence M,I,M,I,M,I.
